// File: rtl/cpu_defs.sv
// Shared definitions for the HI/LO multiply/divide path: op_type encodings,
// controller state encoding and the unit's nominal latency.
// No ports; imported by mul_div_ctrl and anything that talks to the mul_div unit.
package cpu_defs;

    // op_type encodings presented by EX; 6 and 7 are reserved no-ops
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Start-high cycles the unit needs before it raises ready
    localparam int MD_LATENCY = 34;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RELEASE = 2'd3
    } md_state_t;

endpackage

// File: rtl/mul_div_ctrl.sv
// Sequencer between EX and the multi-cycle mul_div unit; owns HI/LO and stalls EX
// while a multiply/divide is in flight. Ports: EX op/operands/flush in, stall out;
// md_* start/operand handshake to the unit; hi/lo, write pulse and sticky timeout out.
module mul_div_ctrl
    import cpu_defs::*;
#(
    parameter int TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [2:0]  op_type_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        md_sel_o,
    output logic        md_signed_o,
    output logic [31:0] md_opa_o,
    output logic [31:0] md_opb_o,
    output logic        md_start_o,
    output logic        md_annul_o,
    input  logic [63:0] md_result_i,
    input  logic        md_ready_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        hilo_we_o,
    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    md_state_t   state, state_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    // Set when RELEASE is reached after a drain/flush: the op now in EX is a new one
    // and must keep waiting. After a normal completion (or BUSY timeout) the op in EX
    // is the one just retired, so it is let go during RELEASE.
    logic        rel_hold, rel_hold_nx;
    logic        start_nx, sel_nx, sgn_nx, err_nx;
    logic [31:0] opa_nx, opb_nx, hi_nx, lo_nx;
    logic        take, is_mul, is_div, is_md, div0, timed_out;

    assign take      = op_valid_i & ~flush_i;
    assign is_mul    = (op_type_i == MD_MULT) | (op_type_i == MD_MULTU);
    assign is_div    = (op_type_i == MD_DIV)  | (op_type_i == MD_DIVU);
    assign is_md     = is_mul | is_div;
    assign div0      = is_div & (opb_i == 32'd0);
    assign timed_out = (tcnt >= TW'(TIMEOUT - 1));
    assign md_annul_o = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tcnt        <= '0;
            rel_hold    <= 1'b0;
            md_start_o  <= 1'b0;
            md_sel_o    <= 1'b0;
            md_signed_o <= 1'b0;
            md_opa_o    <= 32'd0;
            md_opb_o    <= 32'd0;
            hi_o        <= 32'd0;
            lo_o        <= 32'd0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_nx;
            tcnt        <= tcnt_nx;
            rel_hold    <= rel_hold_nx;
            md_start_o  <= start_nx;
            md_sel_o    <= sel_nx;
            md_signed_o <= sgn_nx;
            md_opa_o    <= opa_nx;
            md_opb_o    <= opb_nx;
            hi_o        <= hi_nx;
            lo_o        <= lo_nx;
            err_o       <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        tcnt_nx     = tcnt;
        rel_hold_nx = 1'b0;
        start_nx    = md_start_o;
        sel_nx      = md_sel_o;
        sgn_nx      = md_signed_o;
        opa_nx      = md_opa_o;
        opb_nx      = md_opb_o;
        hi_nx       = hi_o;
        lo_nx       = lo_o;
        err_nx      = err_o;
        hilo_we_o   = 1'b0;
        stall_o     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (take && is_md && !div0) begin
                    sel_nx   = is_mul;
                    sgn_nx   = (op_type_i == MD_MULT) | (op_type_i == MD_DIV);
                    opa_nx   = opa_i;
                    opb_nx   = opb_i;
                    start_nx = 1'b1;
                    tcnt_nx  = '0;
                    state_nx = ST_BUSY;
                    stall_o  = 1'b1;
                end
            end
            ST_BUSY: begin
                stall_o = 1'b1;
                tcnt_nx = tcnt + 1'b1;
                if (flush_i) begin
                    // A flush beats a same-cycle ready: the result belongs to a killed op
                    if (md_ready_i) begin
                        start_nx    = 1'b0;
                        rel_hold_nx = 1'b1;
                        state_nx    = ST_RELEASE;
                    end else begin
                        state_nx = ST_DRAIN;
                    end
                end else if (md_ready_i) begin
                    hi_nx     = md_result_i[63:32];
                    lo_nx     = md_result_i[31:0];
                    hilo_we_o = 1'b1;
                    start_nx  = 1'b0;
                    state_nx  = ST_RELEASE;
                end else if (timed_out) begin
                    err_nx   = 1'b1;
                    start_nx = 1'b0;
                    state_nx = ST_RELEASE;
                end
            end
            ST_DRAIN: begin
                // Start stays high so the unit's iteration counter runs to completion
                stall_o = take & is_md;
                tcnt_nx = tcnt + 1'b1;
                if (md_ready_i || timed_out) begin
                    err_nx      = err_o | ~md_ready_i;
                    start_nx    = 1'b0;
                    rel_hold_nx = 1'b1;
                    state_nx    = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                stall_o  = rel_hold & take & is_md;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        // mthi/mtlo never touch the unit; only BUSY (EX frozen) blocks them
        if (state != ST_BUSY && take) begin
            if (op_type_i == MD_MTHI) begin
                hi_nx     = opa_i;
                hilo_we_o = 1'b1;
            end else if (op_type_i == MD_MTLO) begin
                lo_nx     = opa_i;
                hilo_we_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Bench for mul_div_ctrl with a behavioural mul_div unit model; HI/LO writes are
// checked by a scoreboard monitor against hand-computed expected values.
module tb_mul_div_ctrl;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, flush;
    logic [2:0]  op_type;
    logic [31:0] opa, opb;
    logic        stall_o, md_sel_o, md_signed_o, md_start_o, md_annul_o;
    logic [31:0] md_opa_o, md_opb_o, hi_o, lo_o;
    logic [63:0] md_result;
    logic        md_ready, hilo_we_o, err_o;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mul_div_ctrl #(.TIMEOUT(48)) dut (
        .clk(clk), .rst(rst),
        .op_valid_i(op_valid), .op_type_i(op_type), .opa_i(opa), .opb_i(opb), .flush_i(flush),
        .stall_o(stall_o), .md_sel_o(md_sel_o), .md_signed_o(md_signed_o),
        .md_opa_o(md_opa_o), .md_opb_o(md_opb_o), .md_start_o(md_start_o), .md_annul_o(md_annul_o),
        .md_result_i(md_result), .md_ready_i(md_ready),
        .hi_o(hi_o), .lo_o(lo_o), .hilo_we_o(hilo_we_o), .err_o(err_o)
    );

    // Unit model: ready once start has been high for MD_LATENCY cycles, cleared when start drops
    logic unit_dead;
    int   ucnt;
    always @(posedge clk) begin
        if (rst || !md_start_o) ucnt <= 0;
        else if (ucnt < MD_LATENCY) ucnt <= ucnt + 1;
    end
    assign md_ready = md_start_o && (ucnt == MD_LATENCY) && !unit_dead;

    always_comb begin
        logic signed [63:0] sa, sb;
        md_result = 64'd0;
        sa = {{32{md_opa_o[31]}}, md_opa_o};
        sb = {{32{md_opb_o[31]}}, md_opb_o};
        if (md_sel_o) begin
            if (md_signed_o) md_result = sa * sb;
            else             md_result = {32'd0, md_opa_o} * {32'd0, md_opb_o};
        end else if (md_opb_o != 32'd0) begin
            if (md_signed_o)
                md_result = {32'($signed(md_opa_o) % $signed(md_opb_o)), 32'($signed(md_opa_o) / $signed(md_opb_o))};
            else
                md_result = {md_opa_o % md_opb_o, md_opa_o / md_opb_o};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a write-enable cycle must match the oldest expected {HI,LO}
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && hilo_we_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL hilo_unexpected: got write %h%h expected none", hi_o, lo_o);
                end else begin
                    e = exp_q.pop_front();
                    @(posedge clk);
                    #1;
                    check("hilo", {hi_o, lo_o}, e);
                end
            end
        end
    end

    // Present one op and hold it while stalled; report stall cycles and md_start_o
    // in the first non-stalled cycle
    task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output logic start_after);
        bit done;
        done = 0;
        start_after = 1'b0;
        @(posedge clk);
        #1;
        op_valid = 1'b1; op_type = t; opa = a; opb = b; stalls = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            else begin
                done = 1;
                start_after = md_start_o;
            end
        end
        check("issue_bound", {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    int   s;
    logic st;
    bit   start_seen;

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_type = 3'd0; opa = 32'd0; opb = 32'd0;
        flush = 1'b0; unit_dead = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_ctl", {60'd0, md_start_o, err_o, stall_o, hilo_we_o}, 64'd0);
        check("rst_md", {md_opa_o, md_opb_o}, 64'd0);
        check("rst_sel", {62'd0, md_sel_o, md_signed_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // signed multiply -3 * 5
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
        issue(MD_MULT, 32'hFFFFFFFD, 32'd5, s, st);
        check("mult_stalls", 64'(s), 64'd36);
        check("mult_release_start", {63'd0, st}, 64'd0);

        // unsigned divide 100 / 7
        exp_q.push_back({32'h00000002, 32'h0000000E});
        issue(MD_DIVU, 32'd100, 32'd7, s, st);
        check("divu_stalls", 64'(s), 64'd36);
        check("divu_release_start", {63'd0, st}, 64'd0);

        // signed divide -7 / 2
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, s, st);
        check("div_stalls", 64'(s), 64'd36);

        exp_q.push_back({32'h00000011, 32'hFFFFFFFD});
        issue(MD_MTHI, 32'h11, 32'd0, s, st);
        check("mthi_stalls", 64'(s), 64'd0);
        exp_q.push_back({32'h00000011, 32'h00000022});
        issue(MD_MTLO, 32'h22, 32'd0, s, st);
        check("mtlo_stalls", 64'(s), 64'd0);

        // divide by zero bypasses the unit
        start_seen = 0;
        issue(MD_DIV, 32'd9, 32'd0, s, st);
        check("div0_stalls", 64'(s), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (md_start_o) start_seen = 1;
        end
        check("div0_no_start", {63'd0, start_seen | st}, 64'd0);
        check("div0_hilo", {hi_o, lo_o}, {32'h11, 32'h22});

        issue(3'd6, 32'h5, 32'h5, s, st);
        check("reserved_stalls", 64'(s), 64'd0);

        // flush at BUSY cycle 10, then a multu arrives while draining
        @(posedge clk);
        #1;
        op_valid = 1'b1; op_type = MD_MULT; opa = 32'd3; opb = 32'd4;
        repeat (10) @(posedge clk);
        #1;
        op_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_cycle_stall", {63'd0, stall_o}, 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("drain_stall", {63'd0, stall_o}, 64'd0);
        check("drain_start", {63'd0, md_start_o}, 64'd1);
        check("drain_opa", {32'd0, md_opa_o}, 64'd3);
        exp_q.push_back({32'h00000001, 32'hFFFFFFFE});
        @(posedge clk);
        #1;
        op_valid = 1'b1; op_type = MD_MULTU; opa = 32'hFFFFFFFF; opb = 32'd2;
        s = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stall_o) break;
            s++;
        end
        check("drain_multu_stalls", 64'(s), 64'd61);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        check("flush_hilo", {hi_o, lo_o}, {32'h1, 32'hFFFFFFFE});

        // unit never answers: timeout
        unit_dead = 1'b1;
        issue(MD_MULT, 32'd2, 32'd3, s, st);
        check("timeout_stalls", 64'(s), 64'd49);
        check("timeout_err", {63'd0, err_o}, 64'd1);
        repeat (2) @(negedge clk);
        check("timeout_idle", {62'd0, md_start_o, stall_o}, 64'd0);
        check("timeout_err_sticky", {63'd0, err_o}, 64'd1);
        unit_dead = 1'b0;

        exp_q.push_back({32'h0000ABCD, 32'hFFFFFFFE});
        issue(MD_MTHI, 32'hABCD, 32'd0, s, st);
        repeat (3) @(posedge clk);
        #1;
        check("hi_after_timeout", {32'd0, hi_o}, 64'h0000ABCD);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_ctrl.md
Name: mul_div_ctrl

Overview:
Sequencing controller between the EX stage and the multi-cycle mul_div unit. Accepts MIPS mult/multu/div/divu/mthi/mtlo from EX and drives the unit's start/operand handshake. Stalls the pipeline while the unit is busy and owns the architectural HI/LO registers. Absorbs pipeline flushes without leaving the unit's iteration counter mid-sequence, and bypasses the unit for divide-by-zero.

Parameters:
TIMEOUT, 48, cycles in BUSY/DRAIN before err_o latches (unit nominal latency 34 start-high cycles)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
op_valid_i  in  1  EX holds a HI/LO-class instruction this cycle
op_type_i  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved (no-op)
opa_i  in  32  rs value
opb_i  in  32  rt value
flush_i  in  1  exception/branch flush of EX
stall_o  out  1  freeze EX and earlier stages
md_sel_o  out  1  to unit: 1 multiply, 0 divide
md_signed_o  out  1  to unit: signed operation
md_opa_o  out  32  to unit operand 1
md_opb_o  out  32  to unit operand 2
md_start_o  out  1  to unit start (level; held until ready)
md_annul_o  out  1  to unit annul (tied 0; unit ignores it)
md_result_i  in  64  from unit: {HI,LO}; divide gives {remainder,quotient}
md_ready_i  in  1  from unit: result valid
hi_o  out  32  HI register
lo_o  out  32  LO register
hilo_we_o  out  1  one-cycle pulse, HI/LO updated this edge
err_o  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; hi_o, lo_o = 0; md_start_o, hilo_we_o, err_o = 0; md_opa_o, md_opb_o, md_sel_o, md_signed_o = 0; timeout counter = 0.
- All md_* outputs registered; md_start_o is never combinational.
- States: IDLE, BUSY, DRAIN, RELEASE.
- IDLE, op_valid_i & !flush_i:
  - mthi/mtlo: write hi_o/lo_o = opa_i at the edge; hilo_we_o pulses; no stall; stay IDLE.
  - mult/multu/div/divu with opb_i != 0 or mult/multu: latch operands, sel, signed; md_start_o <= 1; go BUSY; stall_o = 1 this cycle.
  - div/divu with opb_i = 0: no start; hi_o/lo_o unchanged; stay IDLE; no stall.
  - reserved types: no action.
- BUSY: stall_o = 1; md_start_o held 1; operands frozen.
  - md_ready_i = 1: hi_o <= md_result_i[63:32]; lo_o <= md_result_i[31:0]; hilo_we_o pulses; md_start_o <= 0; go RELEASE. Stall drops next cycle.
  - flush_i = 1 (and no ready this cycle): go DRAIN. stall_o = 0 from the next cycle.
  - Ready and flush in the same cycle: flush wins; no HI/LO write; go RELEASE.
- DRAIN: stall_o = 0; md_start_o held 1 so the unit's counter completes. On md_ready_i: discard result; md_start_o <= 0; go RELEASE.
- RELEASE: one cycle with md_start_o = 0 so the unit clears ready/result. Then go IDLE.
  - A mul/div op presented in DRAIN or RELEASE gets stall_o = 1 and is not accepted until IDLE.
  - mthi/mtlo in DRAIN/RELEASE is performed immediately (HI/LO not in flight).
- Timing (mult, no flush): op presented cycle 0; BUSY cycles 1..35; ready seen cycle 35; hilo_we_o pulses at end of cycle 35; stall_o high cycles 0..35 (36 cycles).
- Timeout: counter increments in BUSY/DRAIN and clears on entry. At TIMEOUT, set err_o (sticky until rst), drop md_start_o, go RELEASE, no HI/LO write.
- flush_i in IDLE suppresses acceptance.
- rst mid-operation: controller returns to IDLE. The unit receives its own rst from the same source.

Decomposition:
- Shared package (cpu_defs): op_type encodings MD_MULT..MD_MTLO, state encoding, MD_LATENCY = 34.
- No sub-module; the timeout counter stays inline.

Test Plan:
- mult opa=0xFFFFFFFD, opb=5 -> after 36 stall cycles hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1, single hilo_we_o pulse.
- divu opa=100, opb=7 -> lo_o=0x0000000E, hi_o=0x00000002; md_start_o drops for exactly one RELEASE cycle.
- div opa=0xFFFFFFF9, opb=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- div opa=9, opb=0 with hi_o=0x11, lo_o=0x22 -> md_start_o never rises, stall_o=0, HI/LO unchanged.
- mult started, flush_i at BUSY cycle 10 -> stall_o drops next cycle; md_start_o held until ready; HI/LO unchanged. A multu presented during DRAIN stalls, then completes correctly.
- Unit model never asserts ready, TIMEOUT=48 -> err_o=1 after 48 busy cycles, state returns IDLE, no hilo_we_o. Then mthi 0xABCD -> hi_o=0xABCD.
